// File: rtl/data_mem_ws.sv
// data_mem_ws: MEM-stage data memory with a programmable wait-state count,
// a base-address window, out-of-range detection and a ready/stall output.
// Optional feature macro: DMEM_CLEAR_EN. When it is defined, reset enters a
// CLEAR state that zeroes the array, one word per cycle, before the first
// access is accepted.
module data_mem_ws #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_res,
    input  logic [DATA_W-1:0] Val_Rm,
    input  logic              mem_w_en,
    input  logic              mem_r_en,
    output logic [DATA_W-1:0] res_data,
    output logic              ready,
    output logic              err
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

`ifdef DMEM_CLEAR_EN
    localparam state_e RST_ST = ST_CLEAR;
`else
    localparam state_e RST_ST = ST_IDLE;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
`ifdef DMEM_CLEAR_EN
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              req;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_we;
    logic              acc_re;
    logic [ADDR_W-1:0] acc_off;
    logic [ADDR_W-1:0] acc_word;
    logic              acc_in_range;
    logic [IDX_W-1:0]  acc_idx;
    logic              complete;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign req = mem_w_en | mem_r_en;

    // Access being serviced: live inputs in IDLE, latched copy in WAIT; dual request is a write
    always_comb begin
        acc_addr  = alu_res;
        acc_wdata = Val_Rm;
        acc_we    = mem_w_en;
        acc_re    = mem_r_en & ~mem_w_en;
        if (state_q == ST_WAIT) begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_we    = we_q;
            acc_re    = re_q;
        end
    end

    // Word index and window check; low offset bits are dropped so addresses align down
    assign acc_off      = acc_addr - ADDR_W'(BASE_ADDR);
    assign acc_word     = acc_off >> OFF_W;
    assign acc_in_range = (acc_addr >= ADDR_W'(BASE_ADDR)) && (acc_word < ADDR_W'(DEPTH));
    assign acc_idx      = IDX_W'(acc_word);

    // Completion cycle of an access; reset cancels anything in flight
    always_comb begin
        complete = 1'b0;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                complete = req && (WAIT_STATES == 0);
            end else if (state_q == ST_WAIT) begin
                complete = (cnt_q == '0);
            end
        end
    end

    // State register and latched request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_ST;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
`ifdef DMEM_CLEAR_EN
            clr_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
`ifdef DMEM_CLEAR_EN
            clr_idx_q <= clr_idx_d;
`endif
        end
    end

    // Next-state logic: clear sweep, request capture, wait countdown
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        re_d      = re_q;
`ifdef DMEM_CLEAR_EN
        clr_idx_d = clr_idx_q;
`endif
        unique case (state_q)
            ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                clr_idx_d = IDX_W'(clr_idx_q + 1'b1);
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (req && (WAIT_STATES != 0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_STATES - 1);
                    addr_d  = alu_res;
                    wdata_d = Val_Rm;
                    we_d    = mem_w_en;
                    re_d    = mem_r_en & ~mem_w_en;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: data and error only in the completion cycle, ready also when idle with no request
    always_comb begin
        ready    = 1'b0;
        res_data = '0;
        err      = 1'b0;
        if (complete) begin
            ready = 1'b1;
            err   = ~acc_in_range;
            if (acc_re && acc_in_range) begin
                res_data = mem_q[acc_idx];
            end
        end else if ((state_q == ST_IDLE) && !req) begin
            ready = 1'b1;
        end
    end

    // Array write port: clear sweep takes priority, otherwise an in-range completing write
    always_comb begin
        wr_en   = complete && acc_we && acc_in_range;
        wr_idx  = acc_idx;
        wr_data = acc_wdata;
`ifdef DMEM_CLEAR_EN
        if (!rst && (state_q == ST_CLEAR)) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_q;
            wr_data = '0;
        end
`endif
    end

    // Storage array (not reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_data_mem_ws.sv
// tb_data_mem_ws: directed checks of data_mem_ws with zero wait states
// (instance a) and three wait states (instance b).
module tb_data_mem_ws;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
`ifdef DMEM_CLEAR_EN
    localparam int unsigned CLR_CYC = DEPTH;
`else
    localparam int unsigned CLR_CYC = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, a_we, a_re, a_rdy, a_err;
    logic [31:0]   a_addr;
    logic [DW-1:0] a_wd, a_rd;
    logic          rst_b, b_we, b_re, b_rdy, b_err;
    logic [31:0]   b_addr;
    logic [DW-1:0] b_wd, b_rd;

    logic [31:0]   a_rd_s;
    logic          a_rdy_s, a_err_s;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    data_mem_ws #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_STATES(0)) u_dut_a (
        .clk(clk), .rst(rst_a), .alu_res(a_addr), .Val_Rm(a_wd),
        .mem_w_en(a_we), .mem_r_en(a_re), .res_data(a_rd), .ready(a_rdy), .err(a_err)
    );

    data_mem_ws #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_STATES(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .alu_res(b_addr), .Val_Rm(b_wd),
        .mem_w_en(b_we), .mem_r_en(b_re), .res_data(b_rd), .ready(b_rdy), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle access on instance a, outputs sampled mid low phase
    task automatic a_op(input logic [31:0] addr, input logic [31:0] wd, input logic we, input logic re);
        @(negedge clk);
        a_addr = addr; a_wd = wd; a_we = we; a_re = re;
        #1;
        a_rd_s = a_rd; a_rdy_s = a_rdy; a_err_s = a_err;
    endtask

    // Reset instance a, return the number of cycles ready stays low afterwards
    task automatic a_reset(output int unsigned low);
        @(negedge clk);
        rst_a = 1'b1; a_we = 1'b0; a_re = 1'b0; a_addr = '0; a_wd = '0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        low = 0;
        #1;
        while (!a_rdy && low < 3000) begin
            low++;
            @(negedge clk);
            #1;
        end
    endtask

    // Multi-cycle access on instance b; optionally disturbs inputs while waiting
    task automatic b_op(input logic [31:0] addr, input logic [31:0] wd, input logic we, input logic re,
                        input logic scramble, output int unsigned low, output logic [31:0] rd,
                        output logic er);
        @(negedge clk);
        b_addr = addr; b_wd = wd; b_we = we; b_re = re;
        #1;
        low = 0;
        while (!b_rdy && low < 40) begin
            low++;
            @(negedge clk);
            if (scramble) begin
                b_addr = 32'h0000_0400;
                b_wd   = ~wd;
                b_we   = 1'b1;
            end
            #1;
        end
        rd = b_rd;
        er = b_err;
    endtask

    task automatic b_wait_ready(output int unsigned low);
        low = 0;
        #1;
        while (!b_rdy && low < 3000) begin
            low++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned low;
        logic [31:0] rd;
        logic        er;

        rst_a = 1'b1; a_we = 1'b0; a_re = 1'b0; a_addr = '0; a_wd = '0;
        rst_b = 1'b1; b_we = 1'b0; b_re = 1'b0; b_addr = '0; b_wd = '0;

        // ---------------- instance a: zero wait states ----------------
        a_reset(low);
        check("a_rst_low_cycles", 32'(low), 32'(CLR_CYC));
        check("a_rst_ready", 32'(a_rdy), 32'd1);
        check("a_rst_res", a_rd, 32'h0);
        check("a_rst_err", 32'(a_err), 32'd0);

        a_op(32'h400, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("a_wr400_ready", 32'(a_rdy_s), 32'd1);
        check("a_wr400_err", 32'(a_err_s), 32'd0);
        check("a_wr400_res", a_rd_s, 32'h0);

        a_op(32'h400, 32'h0, 1'b0, 1'b1);
        check("a_rd400_data", a_rd_s, 32'hDEAD_BEEF);
        check("a_rd400_ready", 32'(a_rdy_s), 32'd1);
        check("a_rd400_err", 32'(a_err_s), 32'd0);

        a_op(32'h13FC, 32'h55AA_55AA, 1'b1, 1'b0);
        a_op(32'h3FC, 32'h1111_1111, 1'b1, 1'b0);
        check("a_wr3fc_err", 32'(a_err_s), 32'd1);
        check("a_wr3fc_ready", 32'(a_rdy_s), 32'd1);

        a_op(32'h13FC, 32'h0, 1'b0, 1'b1);
        check("a_rd13fc_data", a_rd_s, 32'h55AA_55AA);
        check("a_rd13fc_err", 32'(a_err_s), 32'd0);

        a_op(32'h1400, 32'h0, 1'b0, 1'b1);
        check("a_rd1400_err", 32'(a_err_s), 32'd1);
        check("a_rd1400_res", a_rd_s, 32'h0);
        check("a_rd1400_ready", 32'(a_rdy_s), 32'd1);

        a_op(32'h402, 32'hA5A5_A5A5, 1'b1, 1'b0);
        a_op(32'h400, 32'h0, 1'b0, 1'b1);
        check("a_misalign_rd400", a_rd_s, 32'hA5A5_A5A5);
        a_op(32'h403, 32'h0, 1'b0, 1'b1);
        check("a_misalign_rd403", a_rd_s, 32'hA5A5_A5A5);

        a_op(32'h404, 32'hCAFE_F00D, 1'b1, 1'b1);
        check("a_dual_res", a_rd_s, 32'h0);
        check("a_dual_err", 32'(a_err_s), 32'd0);
        a_op(32'h404, 32'h0, 1'b0, 1'b1);
        check("a_dual_wrote", a_rd_s, 32'hCAFE_F00D);

        a_op(32'h0, 32'h0, 1'b0, 1'b0);
        check("a_idle_ready", 32'(a_rdy_s), 32'd1);
        check("a_idle_res", a_rd_s, 32'h0);

        // ---------------- instance b: three wait states ----------------
        @(negedge clk);
        rst_b = 1'b0;
        b_wait_ready(low);
        check("b_rst_low_cycles", 32'(low), 32'(CLR_CYC));

        b_op(32'h400, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b0, low, rd, er);
        b_op(32'h404, 32'h1234_5678, 1'b1, 1'b0, 1'b0, low, rd, er);
        check("b_wr404_low", 32'(low), 32'd3);
        check("b_wr404_err", 32'(er), 32'd0);
        check("b_wr404_res", rd, 32'h0);

        b_op(32'h404, 32'h0, 1'b0, 1'b1, 1'b1, low, rd, er);
        check("b_rd404_low", 32'(low), 32'd3);
        check("b_rd404_data", rd, 32'h1234_5678);
        check("b_rd404_err", 32'(er), 32'd0);

        b_op(32'h400, 32'h0, 1'b0, 1'b1, 1'b0, low, rd, er);
        check("b_scramble_ignored", rd, 32'h0BAD_CAFE);

        b_op(32'h408, 32'h0000_0077, 1'b1, 1'b0, 1'b0, low, rd, er);
        b_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, low, rd, er);
        check("b_idle_ready_low", 32'(low), 32'd0);

        // Write of 1 to 0x408, reset during the second WAIT-state cycle
        @(negedge clk);
        b_addr = 32'h408; b_wd = 32'h1; b_we = 1'b1; b_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0; b_we = 1'b0;
        b_wait_ready(low);
        check("b_midrst_low_cycles", 32'(low), 32'(CLR_CYC));

        b_op(32'h408, 32'h0, 1'b0, 1'b1, 1'b0, low, rd, er);
`ifdef DMEM_CLEAR_EN
        check("b_midrst_rd408", rd, 32'h0);
`else
        check("b_midrst_rd408", rd, 32'h0000_0077);
`endif
        check("b_midrst_rd_low", 32'(low), 32'd3);
        check("b_midrst_rd_err", 32'(er), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
